ahb_lite_master: RTL and testbench

- Command-driven AHB-Lite initiator: the requester side that drives ahb_to_apb_bridge (or any AHB-Lite slave) in place of bench tasks.
- Converts a valid/ready command stream into pipelined AHB NONSEQ single transfers.
- The next address phase overlaps the current data phase.
- Handles HREADY wait states and the two-cycle ERROR response.
- Returns one response per command, in order.

---
 rtl/ahb_lite_master.sv | 152 +++++++++++++++
 tb/tb_ahb_lite_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_master
// Brief   : Command-stream to AHB-Lite initiator issuing pipelined NONSEQ
//           single transfers, one in-order response per command.
// Revision: 1.0
// ============================================================================
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP
);

    localparam logic [1:0] C_IDLE   = 2'b00;
    localparam logic [1:0] C_NONSEQ = 2'b10;
    localparam logic [2:0] C_WORD   = 3'b010;

    // Address stage
    logic                  r_a_vld;
    logic                  r_a_write;
    logic [DATA_WIDTH-1:0] r_a_wdata;
    logic                  r_a_hold;
    // Data stage
    logic                  r_d_vld;
    logic                  r_d_write;
    // Registered bus outputs
    logic                  r_hsel;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;

    logic w_advance;
    logic w_done;
    logic w_err1;
    logic w_replay;

    assign w_advance = HREADY && !r_a_hold;
    assign w_done    = r_d_vld && HREADY;
    // First ERROR cycle with a queued address phase: pull it off the bus.
    assign w_err1    = r_d_vld && HRESP && !HREADY && r_a_vld && !r_a_hold;
    assign w_replay  = r_a_hold && HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a_vld   <= 1'b0;
            r_a_write <= 1'b0;
            r_a_wdata <= '0;
            r_a_hold  <= 1'b0;
        end else begin
            if (w_advance) begin
                r_a_vld <= cmd_valid;
                if (cmd_valid) begin
                    r_a_write <= cmd_write;
                    r_a_wdata <= cmd_wdata;
                end
            end
            if (w_err1) begin
                r_a_hold <= 1'b1;
            end else if (w_replay) begin
                r_a_hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_d_vld   <= 1'b0;
            r_d_write <= 1'b0;
            r_hwdata  <= '0;
        end else if (w_advance) begin
            r_d_vld   <= r_a_vld;
            r_d_write <= r_a_write;
            if (r_a_vld && r_a_write) begin
                r_hwdata <= r_a_wdata;
            end
        end else if (w_replay) begin
            r_d_vld <= 1'b0;
        end
    end

    // Address and control stay on the bus through a hold so the replay
    // only needs to re-raise NONSEQ.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hsel   <= 1'b0;
            r_htrans <= C_IDLE;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
        end else if (w_advance) begin
            r_hsel   <= cmd_valid;
            r_htrans <= cmd_valid ? C_NONSEQ : C_IDLE;
            if (cmd_valid) begin
                r_haddr  <= cmd_addr;
                r_hwrite <= cmd_write;
            end
        end else if (w_err1) begin
            r_hsel   <= 1'b0;
            r_htrans <= C_IDLE;
        end else if (w_replay) begin
            r_hsel   <= 1'b1;
            r_htrans <= C_NONSEQ;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_rdata <= (w_done && !r_d_write) ? HRDATA : '0;
            r_rsp_error <= w_done && HRESP;
        end
    end

    assign cmd_ready = w_advance;
    assign HSEL      = r_hsel;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = C_WORD;
    assign HWDATA    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_lite_master
// Brief   : Directed and random bench for ahb_lite_master with a behavioural
//           AHB-Lite memory slave and an in-order response model.
// Revision: 1.0
// ============================================================================
module tb_ahb_lite_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t        expq[$];
    logic [31:0] refmem[64];
    logic [31:0] smem[64];

    int          fixed_wait;
    int          s_nw;
    logic        s_dph, s_write, s_err;
    logic [31:0] s_addr;
    int          s_cnt;

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic is_err(input logic [31:0] a);
        return (a[7:0] == 8'h40) || (a[7:4] == 4'hC);
    endfunction

    always @(negedge HCLK) s_nw = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));

    // Memory slave: word array, programmable waits, two-cycle ERROR on error addresses.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
            HRDATA <= '0;
            s_dph  <= 1'b0;
            s_err  <= 1'b0;
            s_cnt  <= 0;
        end else if (HREADY) begin
            if (s_dph && !s_err && s_write) smem[s_addr[7:2]] <= HWDATA;
            if (HSEL && HTRANS == 2'b10) begin
                s_dph   <= 1'b1;
                s_addr  <= HADDR;
                s_write <= HWRITE;
                s_err   <= is_err(HADDR);
                if (is_err(HADDR)) begin
                    HREADY <= 1'b0;
                    HRESP  <= 1'b1;
                end else if (s_nw == 0) begin
                    HREADY <= 1'b1;
                    HRESP  <= 1'b0;
                    if (HWRITE) HRDATA <= '0;
                    else if (s_dph && !s_err && s_write && s_addr[7:2] == HADDR[7:2]) HRDATA <= HWDATA;
                    else HRDATA <= smem[HADDR[7:2]];
                end else begin
                    HREADY <= 1'b0;
                    HRESP  <= 1'b0;
                    s_cnt  <= s_nw;
                end
            end else begin
                s_dph  <= 1'b0;
                HREADY <= 1'b1;
                HRESP  <= 1'b0;
            end
        end else if (s_err) begin
            HREADY <= 1'b1;
            HRDATA <= '0;
        end else if (s_cnt == 1) begin
            HREADY <= 1'b1;
            HRDATA <= s_write ? 32'h0 : smem[s_addr[7:2]];
        end else begin
            s_cnt <= s_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            total++;
            assert (expq.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected: observed=1 expected=0");
            end
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_error", 64'(rsp_error), 64'(e.err));
            end
        end
    end

    // Call #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int   n;
        logic rdy;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        forever begin
            rdy = cmd_ready;
            @(posedge HCLK);
            #1;
            if (rdy) break;
            n++;
            if (n > 60) begin
                chk("accept_timeout", 64'(n), 64'(0));
                break;
            end
        end
        e.err = is_err(a);
        if (w) begin
            e.rdata = '0;
            if (!e.err) refmem[a[7:2]] = d;
        end else begin
            e.rdata = e.err ? 32'h0 : refmem[a[7:2]];
        end
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        chk("drain_left", 64'(expq.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            refmem[i] = '0;
            smem[i]   = '0;
        end
        fixed_wait = 0;
        HRESETn = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #1;
        chk("rst_htrans", 64'(HTRANS), 64'(0));
        chk("rst_hsel", 64'(HSEL), 64'(0));
        chk("rst_haddr", 64'(HADDR), 64'(0));
        chk("rst_hwdata", 64'(HWDATA), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("hsize", 64'(HSIZE), 64'(3'b010));
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(1);

        // Single write, zero waits: latency check
        send(1'b1, 32'h4, 32'hBEEF_BEEF);
        cmd_valid = 1'b0;
        chk("sw_htrans", 64'(HTRANS), 64'(2'b10));
        chk("sw_haddr", 64'(HADDR), 64'(32'h4));
        chk("sw_hwrite", 64'(HWRITE), 64'(1));
        chk("sw_hsel", 64'(HSEL), 64'(1));
        idle(1);
        chk("sw_htrans_idle", 64'(HTRANS), 64'(0));
        chk("sw_hwdata", 64'(HWDATA), 64'(32'hBEEF_BEEF));
        chk("sw_rsp_valid_early", 64'(rsp_valid), 64'(0));
        idle(1);
        chk("sw_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("sw_rsp_error", 64'(rsp_error), 64'(0));
        drain();

        // Read after write, back to back
        send(1'b1, 32'h0C, 32'hFACE_FEED);
        send(1'b0, 32'h0C, 32'h0);
        drain();

        // Pipelined writes then read-back
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'h20 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            if (i > 0) begin
                chk("pipe_haddr", 64'(HADDR), 64'(32'h20 + 32'(4 * i)));
                chk("pipe_hwdata", 64'(HWDATA), 64'(32'h1000_0000 + 32'(i - 1)));
            end
        end
        for (int i = 0; i < 4; i++) send(1'b0, 32'h20 + 32'(4 * i), 32'h0);
        drain();

        // Three wait states during a write data phase
        fixed_wait = 3;
        send(1'b1, 32'h30, 32'h5A5A_0030);
        send(1'b0, 32'h34, 32'h0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h38;
        for (int i = 0; i < 3; i++) begin
            chk("ws_hready", 64'(HREADY), 64'(0));
            chk("ws_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("ws_haddr", 64'(HADDR), 64'(32'h34));
            chk("ws_hwrite", 64'(HWRITE), 64'(0));
            chk("ws_hwdata", 64'(HWDATA), 64'(32'h5A5A_0030));
            if (i < 2) begin
                @(posedge HCLK);
                #1;
            end
        end
        fixed_wait = 0;
        cmd_valid = 1'b0;
        drain();

        // ERROR on 0x40 with 0x44 queued behind it
        send(1'b1, 32'h40, 32'hDEAD_0040);
        send(1'b0, 32'h44, 32'h0);
        cmd_valid = 1'b0;
        idle(1);
        chk("err_htrans_idle", 64'(HTRANS), 64'(0));
        chk("err_hsel", 64'(HSEL), 64'(0));
        chk("err_cmd_ready", 64'(cmd_ready), 64'(0));
        idle(1);
        chk("err_replay_htrans", 64'(HTRANS), 64'(2'b10));
        chk("err_replay_haddr", 64'(HADDR), 64'(32'h44));
        chk("err_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("err_rsp_error", 64'(rsp_error), 64'(1));
        drain();

        // Asynchronous reset during a stalled data phase
        fixed_wait = 3;
        send(1'b0, 32'h08, 32'h0);
        cmd_valid = 1'b0;
        idle(1);
        #2;
        HRESETn = 1'b0;
        #1;
        expq.delete();
        chk("arst_htrans", 64'(HTRANS), 64'(0));
        chk("arst_hsel", 64'(HSEL), 64'(0));
        chk("arst_haddr", 64'(HADDR), 64'(0));
        chk("arst_hwrite", 64'(HWRITE), 64'(0));
        chk("arst_hwdata", 64'(HWDATA), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        fixed_wait = 0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(4);
        send(1'b1, 32'h50, 32'h0BAD_CAFE);
        send(1'b0, 32'h50, 32'h0);
        drain();

        // Random traffic with random waits and error addresses
        fixed_wait = -1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
